// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM frame scheduler.
// Holds the byte width, the receiver state encoding and a duty-lane extraction helper.
package pwm_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_W  = 8;
  localparam int MAX_CH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  // Extracts lane idx of a packed duty vector whose lanes are width bits wide.
  function automatic logic [MAX_W-1:0] duty_slice(
    input logic [MAX_W*MAX_CH-1:0] vec,
    input int                      idx,
    input int                      width
  );
    logic [MAX_W*MAX_CH-1:0] sh;
    logic [MAX_W:0]          mask;
    sh   = vec >> (idx * width);
    mask = (MAX_W+1)'(1) << width;
    mask = mask - (MAX_W+1)'(1);
    return sh[MAX_W-1:0] & mask[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_frame_sched_counter.sv
// Free-running PWM period counter shared by all channel comparators.
// Also flags the last cycle of a period, which is where pending duties may be committed.
module pwm_period_counter #(
  parameter int pwm_width = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [pwm_width-1:0] pwm_count,
  output logic                 period_start,
  output logic                 commit_strobe
);

  logic [pwm_width-1:0] r_count;
  logic                 r_period_start;

  // Reset parks the counter at max so the first released cycle reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count        <= '1;
      r_period_start <= 1'b0;
    end else begin
      r_count        <= r_count + pwm_width'(1);
      r_period_start <= (r_count == '1);
    end
  end

  assign pwm_count     = r_count;
  assign period_start  = r_period_start;
  assign commit_strobe = (r_count == '1);

endmodule

// File: rtl/pwm_frame_sched.sv
// Assembles SPI frames into per-channel duties and commits them on PWM period boundaries.
//   state | meaning
//   IDLE  | nCS high, waiting for a frame start; stray bytes are ignored
//   RECV  | frame open, bytes fill staging until all channels are written
module pwm_frame_sched
  import pwm_pkg::*;
#(
  parameter int pwm_width = 5,
  parameter int num_pwm   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         frame_end,
  input  logic                         rx_valid,
  input  logic [BYTE_W-1:0]            rx_data,
  output logic [pwm_width-1:0]         pwm_count,
  output logic                         period_start,
  output logic [num_pwm*pwm_width-1:0] duty_out,
  output logic                         update_pending,
  output logic                         frame_err
);

  localparam int DW    = num_pwm * pwm_width;
  localparam int CNT_W = $clog2(num_pwm + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(num_pwm);

  rx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_byte_cnt, w_cnt_nxt, w_cnt_eff;
  logic [DW-1:0]    r_staging, w_staging_nxt, w_stage_frame;
  logic [DW-1:0]    r_pending, w_pending_nxt;
  logic [DW-1:0]    r_duty, w_duty_nxt;
  logic             r_update_pending, w_upd_nxt;
  logic             r_frame_err, w_err_nxt;
  logic             w_frame_ok;
  logic             w_commit;
  logic [pwm_width-1:0] w_byte;

  pwm_period_counter #(
    .pwm_width(pwm_width)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .pwm_count    (pwm_count),
    .period_start (period_start),
    .commit_strobe(w_commit)
  );

  assign w_byte = rx_data[pwm_width-1:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_byte_cnt;
    w_cnt_eff     = r_byte_cnt;
    w_stage_frame = r_staging;
    w_pending_nxt = r_pending;
    w_duty_nxt    = r_duty;
    w_upd_nxt     = r_update_pending;
    w_err_nxt     = 1'b0;
    w_frame_ok    = 1'b0;

    // A byte belongs to the open frame only when no new frame starts this cycle.
    if (r_state == RECV && rx_valid && !frame_start && r_byte_cnt < CNT_FULL) begin
      w_stage_frame[int'(r_byte_cnt)*pwm_width +: pwm_width] = w_byte;
      w_cnt_eff = r_byte_cnt + CNT_W'(1);
    end
    w_staging_nxt = w_stage_frame;

    case (r_state)
      IDLE: ;
      RECV: begin
        if (frame_end) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = w_cnt_eff;
          if (w_cnt_eff == CNT_FULL) w_frame_ok = 1'b1;
          else                       w_err_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_eff;
          if (frame_start) w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (frame_start) begin
      w_state_nxt = RECV;
      w_cnt_nxt   = '0;
      if (rx_valid) begin
        w_staging_nxt[pwm_width-1:0] = w_byte;
        w_cnt_nxt = CNT_W'(1);
      end
    end

    // Commit uses the old pending value, so a frame landing here waits one more period.
    if (w_commit && r_update_pending) begin
      w_duty_nxt = r_pending;
      w_upd_nxt  = 1'b0;
    end
    if (w_frame_ok) begin
      w_pending_nxt = w_stage_frame;
      w_upd_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_byte_cnt       <= '0;
      r_staging        <= '0;
      r_pending        <= '0;
      r_duty           <= '0;
      r_update_pending <= 1'b0;
      r_frame_err      <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_byte_cnt       <= w_cnt_nxt;
      r_staging        <= w_staging_nxt;
      r_pending        <= w_pending_nxt;
      r_duty           <= w_duty_nxt;
      r_update_pending <= w_upd_nxt;
      r_frame_err      <= w_err_nxt;
    end
  end

  assign duty_out       = r_duty;
  assign update_pending = r_update_pending;
  assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_pwm_frame_sched.sv
// Scoreboard bench for pwm_frame_sched: frames are modelled as transactions (end cycle, duties)
// and a monitor derives expected counter, duty, pending and error outputs from them.
module tb_pwm_frame_sched;

  localparam int W   = 5;
  localparam int N   = 3;
  localparam int PER = 1 << W;

  typedef struct {
    int               e;
    logic [N*W-1:0]   v;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0, frame_end = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [W-1:0]   pwm_count;
  logic           period_start;
  logic [N*W-1:0] duty_out;
  logic           update_pending;
  logic           frame_err;

  acc_t acc_q[$];
  int   err_q[$];
  logic [7:0] bq[$];
  logic [N*W-1:0] exp_duty = '0;
  int   tcyc = -1;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  pwm_frame_sched #(.pwm_width(W), .num_pwm(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .pwm_count     (pwm_count),
    .period_start  (period_start),
    .duty_out      (duty_out),
    .update_pending(update_pending),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; cycle k should show pwm_count == k mod period.
  always @(posedge clk) tcyc <= rst ? -1 : tcyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, tcyc, act, exp);
    end
  endtask

  // Monitor: pops scoreboard entries as the DUT reaches boundaries and error slots.
  initial begin
    int t;
    bit exp_err;
    bit exp_upd;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        t = tcyc;
        if (t < 0) begin
          acc_q.delete();
          err_q.delete();
          exp_duty = '0;
          chk("rst_pwm_count", 32'(pwm_count), PER - 1);
          chk("rst_period_start", 32'(period_start), 0);
          chk("rst_duty_out", 32'(duty_out), 0);
          chk("rst_update_pending", 32'(update_pending), 0);
          chk("rst_frame_err", 32'(frame_err), 0);
        end else begin
          chk("pwm_count", 32'(pwm_count), t % PER);
          chk("period_start", 32'(period_start), 32'((t % PER) == 0));
          if ((t % PER) == 0)
            while (acc_q.size() > 0 && acc_q[0].e <= t - 2) begin
              exp_duty = acc_q[0].v;
              void'(acc_q.pop_front());
            end
          chk("duty_out", 32'(duty_out), 32'(exp_duty));
          exp_upd = (acc_q.size() > 0) && (acc_q[0].e <= t - 1);
          chk("update_pending", 32'(update_pending), 32'(exp_upd));
          exp_err = (err_q.size() > 0) && (err_q[0] == t);
          if (exp_err) void'(err_q.pop_front());
          chk("frame_err", 32'(frame_err), 32'(exp_err));
        end
      end
    end
  end

  task automatic step(input logic fs, input logic fe, input logic rv, input logic [7:0] d);
    @(posedge clk);
    #1;
    frame_start = fs;
    frame_end   = fe;
    rx_valid    = rv;
    rx_data     = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Holds off until the next driven cycle has pwm_count == end_at (bounded).
  task automatic wait_to(input int end_at);
    if (end_at >= 0)
      for (int k = 0; k < 2 * PER && ((tcyc + 1) % PER) != end_at; k++) idle(1);
  endtask

  task automatic gen_bytes(input int nb);
    bq.delete();
    for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
  endtask

  // Sends the bytes in bq as one frame and records the expected outcome.
  task automatic run_frame(input bit fos, input bit loe, input int end_at, input int gmax);
    logic [N*W-1:0] v;
    logic [7:0] b;
    int e;
    int nb;
    bit ended;
    v = '0;
    e = 0;
    ended = 1'b0;
    nb = bq.size();
    for (int i = 0; i < nb && i < N; i++) begin
      b = bq[i];
      v[i*W +: W] = b[W-1:0];
    end
    if (fos && nb > 0) step(1'b1, 1'b0, 1'b1, bq[0]);
    else               step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = (fos && nb > 0) ? 1 : 0; i < nb; i++) begin
      repeat ($urandom_range(gmax, 0)) step(1'b0, 1'b0, 1'b0, 8'($urandom));
      if (i == nb - 1 && loe) begin
        wait_to(end_at);
        step(1'b0, 1'b1, 1'b1, bq[i]);
        e = tcyc;
        ended = 1'b1;
      end else begin
        step(1'b0, 1'b0, 1'b1, bq[i]);
      end
    end
    if (!ended) begin
      wait_to(end_at);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      e = tcyc;
    end
    if (nb >= N) acc_q.push_back('{e: e, v: v});
    else         err_q.push_back(e + 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(PER + 3);

    // Known bytes, frame closing at count 10.
    bq.delete();
    bq.push_back(8'h03); bq.push_back(8'h1F); bq.push_back(8'hE8);
    run_frame(1'b0, 1'b0, 10, 1);
    idle(PER + 4);

    // Short frame is discarded.
    gen_bytes(2);
    run_frame(1'b0, 1'b0, -1, 1);
    idle(PER);

    // Two frames within one period: only the later one should ever appear.
    wait_to(1);
    gen_bytes(3); run_frame(1'b0, 1'b0, -1, 0);
    gen_bytes(3); run_frame(1'b0, 1'b0, -1, 0);
    idle(PER + 4);

    // Second frame ends exactly on the commit cycle while the first is pending.
    gen_bytes(3); run_frame(1'b0, 1'b0, 2, 0);
    gen_bytes(3); run_frame(1'b0, 1'b1, PER - 1, 0);
    idle(2 * PER + 4);

    // Excess bytes are dropped silently.
    gen_bytes(6); run_frame(1'b0, 1'b0, -1, 1);
    idle(PER + 2);

    // nCS glitch: restart inside an open frame, then a good frame.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    err_q.push_back(tcyc + 1);
    bq.delete();
    bq.push_back(8'h11); bq.push_back(8'h02); bq.push_back(8'h1C);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, bq[i]);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    acc_q.push_back('{e: tcyc, v: {bq[2][W-1:0], bq[1][W-1:0], bq[0][W-1:0]}});
    idle(PER + 4);

    // Reset in the middle of a frame, then a normal frame.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hA5);
    idle(1);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);
    gen_bytes(3); run_frame(1'b0, 1'b0, -1, 1);
    idle(PER + 4);

    // Randomised frames: lengths, gaps, coincident byte/start and byte/end, stray bytes.
    for (int f = 0; f < 60; f++) begin
      gen_bytes($urandom_range(6, 1));
      run_frame(1'($urandom), 1'($urandom),
                ($urandom_range(1, 0) == 1) ? -1 : int'($urandom_range(PER - 1, 0)), 2);
      repeat ($urandom_range(4, 0)) step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
    end
    idle(2 * PER + 4);

    chk("err_q_drained", 32'(err_q.size()), 0);
    chk("acc_q_drained", 32'(acc_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", tcyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
